// File: rtl/rsa_frame_loader_if.sv
// Stream and bram-port bundle between the frame source / mon_exp side and
// rsa_frame_loader.
//   master : frame source and mon_exp side. Drives in_data, in_valid and stop,
//            and observes everything else.
//   slave  : the loader. Accepts bytes, presents the held operands, drives the
//            bram second write port, start and busy.
interface rsa_frame_loader_if #(
    parameter int bitLen = 512,
    parameter int ABITS  = 8,
    parameter int DBITS  = 512
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [bitLen-1:0] n;
    logic [bitLen-1:0] e;
    logic [9:0]        e_idx;
    logic [9:0]        mp_count;
    logic [ABITS-1:0]  wr_addr2;
    logic [DBITS-1:0]  wr_data2;
    logic              wr_en2;
    logic              start;
    logic              stop;
    logic              busy;

    modport master (
        output in_data, in_valid, stop,
        input  in_ready, n, e, e_idx, mp_count, wr_addr2, wr_data2, wr_en2, start, busy
    );

    modport slave (
        input  in_data, in_valid, stop,
        output in_ready, n, e, e_idx, mp_count, wr_addr2, wr_data2, wr_en2, start, busy
    );
endinterface

// File: rtl/rsa_frame_loader.sv
// rsa_frame_loader: receives a byte-serial operand frame
// (n, e, e_idx, mp_count, X_bar, M_bar; every field LSB byte first) and
// assembles it into full-width words. X_bar and M_bar are written into the
// bram second write port as (0, X_bar), (1, 0), (2, M_bar), (3, 0). After
// that it pulses start and waits for a fresh rising edge of stop from mon_exp.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : in_data/in_valid/in_ready byte stream; n, e, e_idx,
//                       mp_count held outputs; wr_addr2/wr_data2/wr_en2 bram
//                       port; start pulse; stop level in; busy
module rsa_frame_loader #(
    parameter int bitLen = 512,
    parameter int ABITS  = 8,
    parameter int DBITS  = 512
) (
    input logic               clk,
    input logic               rst,
    rsa_frame_loader_if.slave bus
);
    localparam int BYTES = bitLen / 8;
    localparam int CW    = $clog2(BYTES + 1);
    localparam int IW    = $clog2(bitLen);

    typedef enum logic [3:0] {
        RX_N     = 4'd0,
        RX_E     = 4'd1,
        RX_EIDX  = 4'd2,
        RX_MPC   = 4'd3,
        RX_X     = 4'd4,
        WR_X0    = 4'd5,
        WR_X1    = 4'd6,
        RX_M     = 4'd7,
        WR_M0    = 4'd8,
        WR_M1    = 4'd9,
        ST_START = 4'd10,
        ST_WAIT  = 4'd11
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     last_idx_s;
    logic [IW-1:0]     bidx_s;
    logic [bitLen-1:0] stage_r, stage_s;
    logic              stop_q_r;
    logic              hs_s, last_s, stop_rise_s;

    logic              in_ready_r, in_ready_d;
    logic              wr_en_r, wr_en_d;
    logic [ABITS-1:0]  wr_addr_r, wr_addr_d;
    logic [DBITS-1:0]  wr_data_r, wr_data_d;
    logic              start_r, start_d;
    logic              busy_r, busy_d;
    logic [bitLen-1:0] n_r, e_r;
    logic [9:0]        e_idx_r, mpc_r;

    // in_ready_r is only ever high in receive states, so a handshake implies one.
    assign hs_s        = bus.in_valid & in_ready_r;
    assign last_s      = hs_s & (cnt_r == last_idx_s);
    assign stop_rise_s = bus.stop & ~stop_q_r;
    assign bidx_s      = IW'({cnt_r, 3'b000});

    // Index of the final byte of the field currently being received.
    always_comb begin
        if ((state_r == RX_EIDX) || (state_r == RX_MPC)) begin
            last_idx_s = CW'(1);
        end else begin
            last_idx_s = CW'(BYTES - 1);
        end
    end

    // Staging word with the byte of this cycle's handshake merged in.
    always_comb begin
        stage_s = stage_r;
        if (hs_s) begin
            stage_s[bidx_s +: 8] = bus.in_data;
        end else begin
            stage_s = stage_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RX_N:     if (last_s) state_s = RX_E;    else state_s = state_r;
            RX_E:     if (last_s) state_s = RX_EIDX; else state_s = state_r;
            RX_EIDX:  if (last_s) state_s = RX_MPC;  else state_s = state_r;
            RX_MPC:   if (last_s) state_s = RX_X;    else state_s = state_r;
            RX_X:     if (last_s) state_s = WR_X0;   else state_s = state_r;
            WR_X0:    state_s = WR_X1;
            WR_X1:    state_s = RX_M;
            RX_M:     if (last_s) state_s = WR_M0;   else state_s = state_r;
            WR_M0:    state_s = WR_M1;
            WR_M1:    state_s = ST_START;
            ST_START: state_s = ST_WAIT;
            ST_WAIT:  if (stop_rise_s) state_s = RX_N; else state_s = state_r;
            default:  state_s = RX_N;
        endcase
    end

    // Output decode from the next state, so registered outputs line up with
    // the state they belong to. The low bram words take the just-completed
    // staging word, zero-extended.
    always_comb begin
        in_ready_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        start_d    = 1'b0;
        case (state_s)
            RX_N, RX_E, RX_EIDX, RX_MPC, RX_X, RX_M: in_ready_d = 1'b1;
            WR_X0: begin
                wr_en_d                = 1'b1;
                wr_addr_d              = ABITS'(0);
                wr_data_d[bitLen-1:0]  = stage_s;
            end
            WR_X1: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ABITS'(1);
            end
            WR_M0: begin
                wr_en_d                = 1'b1;
                wr_addr_d              = ABITS'(2);
                wr_data_d[bitLen-1:0]  = stage_s;
            end
            WR_M1: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ABITS'(3);
            end
            ST_START: start_d = 1'b1;
            default:  in_ready_d = 1'b0;
        endcase
        if (hs_s) begin
            busy_d = 1'b1;
        end else if ((state_r == ST_WAIT) && stop_rise_s) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_r;
        end
    end

    // State register and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RX_N;
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= '0;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
            stop_q_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= in_ready_d;
            wr_en_r    <= wr_en_d;
            wr_addr_r  <= wr_addr_d;
            wr_data_r  <= wr_data_d;
            start_r    <= start_d;
            busy_r     <= busy_d;
            stop_q_r   <= bus.stop;
        end
    end

    // Byte counter and staging register; both clear at every field boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            stage_r <= '0;
        end else if (last_s) begin
            cnt_r   <= '0;
            stage_r <= '0;
        end else if (hs_s) begin
            cnt_r   <= cnt_r + CW'(1);
            stage_r <= stage_s;
        end else begin
            cnt_r   <= cnt_r;
            stage_r <= stage_r;
        end
    end

    // Held operand outputs: each changes only when its own field completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_r     <= '0;
            e_r     <= '0;
            e_idx_r <= '0;
            mpc_r   <= '0;
        end else if (last_s) begin
            if (state_r == RX_N)    n_r     <= stage_s;
            if (state_r == RX_E)    e_r     <= stage_s;
            if (state_r == RX_EIDX) e_idx_r <= stage_s[9:0];
            if (state_r == RX_MPC)  mpc_r   <= stage_s[9:0];
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.wr_en2   = wr_en_r;
    assign bus.wr_addr2 = wr_addr_r;
    assign bus.wr_data2 = wr_data_r;
    assign bus.start    = start_r;
    assign bus.busy     = busy_r;
    assign bus.n        = n_r;
    assign bus.e        = e_r;
    assign bus.e_idx    = e_idx_r;
    assign bus.mp_count = mpc_r;
endmodule

// File: tb/tb_rsa_frame_loader.sv
// Self-checking bench for rsa_frame_loader: frames are built from field
// values, expected bram writes and start-time operands go into queues, and a
// negedge monitor pops and compares whenever the loader writes or starts.
module tb_rsa_frame_loader;
    localparam int BL = 512;
    localparam int AB = 8;
    localparam int DB = 512;
    localparam int NB = BL / 8;

    typedef logic [7:0] bq_t[$];
    typedef struct packed { logic [AB-1:0] addr; logic [DB-1:0] data; } wr_t;
    typedef struct packed { logic [BL-1:0] n; logic [BL-1:0] e; logic [9:0] eidx; logic [9:0] mpc; } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_hs_cyc = 0;
    wr_t  exp_wr_q[$];
    st_t  exp_st_q[$];
    wr_t  w;
    st_t  s;

    rsa_frame_loader_if #(.bitLen(BL), .ABITS(AB), .DBITS(DB)) bus();

    rsa_frame_loader #(.bitLen(BL), .ABITS(AB), .DBITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BL-1:0] act, input logic [BL-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en2) begin
                if (exp_wr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got addr %0h expected no write", bus.wr_addr2);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("wr_addr2", BL'(bus.wr_addr2), BL'(w.addr));
                    check("wr_data2", BL'(bus.wr_data2), BL'(w.data));
                end
            end else begin
                check("idle_wr_addr2", BL'(bus.wr_addr2), BL'(0));
                check("idle_wr_data2", BL'(bus.wr_data2), BL'(0));
            end
            if (bus.start) begin
                if (exp_st_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_start: got start=1 expected 0");
                end else begin
                    s = exp_st_q.pop_front();
                    check("start_n", bus.n, s.n);
                    check("start_e", bus.e, s.e);
                    check("start_e_idx", BL'(bus.e_idx), BL'(s.eidx));
                    check("start_mp_count", BL'(bus.mp_count), BL'(s.mpc));
                    check("start_latency", BL'(cyc + 1 - last_hs_cyc), BL'(3));
                end
            end
        end
    end

    function automatic logic [BL-1:0] rnd_word();
        logic [BL-1:0] r;
        for (int i = 0; i < BL / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Build the byte stream and, for complete frames, push the expected response.
    task automatic build(input logic [BL-1:0] n, input logic [BL-1:0] e, input logic [15:0] ei,
                         input logic [15:0] mc, input logic [BL-1:0] x, input logic [BL-1:0] m,
                         input bit expect_it, output bq_t b);
        b = {};
        for (int k = 0; k < NB; k++) b.push_back(n[8*k +: 8]);
        for (int k = 0; k < NB; k++) b.push_back(e[8*k +: 8]);
        b.push_back(ei[7:0]); b.push_back(ei[15:8]);
        b.push_back(mc[7:0]); b.push_back(mc[15:8]);
        for (int k = 0; k < NB; k++) b.push_back(x[8*k +: 8]);
        for (int k = 0; k < NB; k++) b.push_back(m[8*k +: 8]);
        if (expect_it) begin
            exp_wr_q.push_back('{addr: AB'(0), data: DB'(x)});
            exp_wr_q.push_back('{addr: AB'(1), data: DB'(0)});
            exp_wr_q.push_back('{addr: AB'(2), data: DB'(m)});
            exp_wr_q.push_back('{addr: AB'(3), data: DB'(0)});
            exp_st_q.push_back('{n: n, e: e, eidx: ei[9:0], mpc: mc[9:0]});
        end
    endtask

    // gap_mode 0: valid held high; 1: 3 idle cycles before every 5th byte; 2: random gaps.
    task automatic send_bytes(input bq_t b, input int gap_mode);
        int  idx = 0;
        int  budget = 0;
        int  gapped = -1;
        bit  v, hs;
        while (idx < b.size()) begin
            if (gap_mode == 1 && idx > 0 && (idx % 5) == 0 && gapped != idx) begin
                gapped = idx;
                bus.in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                v = (gap_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.in_valid = v;
                bus.in_data  = v ? b[idx] : 8'($urandom);
                hs = v && bus.in_ready;
                @(negedge clk);
                if (hs) begin
                    idx++;
                    last_hs_cyc = cyc;
                end
            end
            budget++;
            if (budget > 5000) begin
                tests++; fails++;
                $display("FAIL send_timeout: got %0d bytes accepted expected %0d", idx, b.size());
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && (exp_wr_q.size() != 0 || exp_st_q.size() != 0); i++) @(negedge clk);
        check("done_pending", BL'(exp_wr_q.size() + exp_st_q.size()), BL'(0));
        @(negedge clk);
        check("wait_in_ready", BL'(bus.in_ready), BL'(0));
        check("wait_busy", BL'(bus.busy), BL'(1));
    endtask

    // Drop stop, confirm the loader is still parked, then give a fresh rising edge.
    task automatic release_wait();
        bus.stop = 1'b0;
        repeat (3) @(negedge clk);
        check("held_before_rise", BL'(bus.in_ready), BL'(0));
        bus.stop = 1'b1;
        @(negedge clk);
        check("release_in_ready", BL'(bus.in_ready), BL'(1));
        check("release_busy", BL'(bus.busy), BL'(0));
    endtask

    initial begin
        bq_t b;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.stop     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", BL'(bus.in_ready), BL'(0));
        check("rst_n", bus.n, BL'(0));
        check("rst_busy", BL'(bus.busy), BL'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", BL'(bus.in_ready), BL'(1));

        // Frame 1, valid held high.
        build(BL'(589), BL'(300), 16'd8, 16'd10, BL'(435), BL'(571), 1'b1, b);
        send_bytes(b, 0);
        wait_done();

        // Bytes offered in WAIT are not consumed.
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            @(negedge clk);
            check("wait_hold_in_ready", BL'(bus.in_ready), BL'(0));
        end
        bus.in_valid = 1'b0;
        release_wait();

        // Frame 2 with stop still high; n of frame 1 stays until frame 2's n completes.
        build(BL'(77), BL'(5), 16'd2, 16'd10, BL'(1), BL'(2), 1'b1, b);
        send_bytes(b[0:NB-2], 0);
        check("n_held_old", bus.n, BL'(589));
        send_bytes(b[NB-1:NB-1], 0);
        check("n_new", bus.n, BL'(77));
        send_bytes(b[NB:$], 0);
        wait_done();
        repeat (5) @(negedge clk);
        check("stale_stop_no_release", BL'(bus.in_ready), BL'(0));
        release_wait();

        // Frame 1 again with periodic valid gaps.
        build(BL'(589), BL'(300), 16'd8, 16'd10, BL'(435), BL'(571), 1'b1, b);
        send_bytes(b, 1);
        wait_done();
        release_wait();

        // Upper bits of the 2-byte fields are discarded.
        build(rnd_word(), rnd_word(), 16'hFFFF, 16'hFC0A, rnd_word(), rnd_word(), 1'b1, b);
        send_bytes(b, 2);
        wait_done();
        check("e_idx_max", BL'(bus.e_idx), BL'(1023));
        check("mp_count_trunc", BL'(bus.mp_count), BL'(10));
        release_wait();

        // Asynchronous reset after 30 bytes of e; partial frame discarded.
        bus.stop = 1'b0;
        build(rnd_word(), rnd_word(), 16'd3, 16'd4, rnd_word(), rnd_word(), 1'b0, b);
        send_bytes(b[0:NB+29], 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_n", bus.n, BL'(0));
        check("arst_e", bus.e, BL'(0));
        check("arst_e_idx", BL'(bus.e_idx), BL'(0));
        check("arst_mp_count", BL'(bus.mp_count), BL'(0));
        check("arst_ctrl", BL'({bus.wr_en2, bus.start, bus.busy, bus.in_ready}), BL'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_release_in_ready", BL'(bus.in_ready), BL'(1));
        build(BL'(589), BL'(300), 16'd8, 16'd10, BL'(435), BL'(571), 1'b1, b);
        send_bytes(b, 0);
        wait_done();
        release_wait();

        // Random frames with random gaps.
        for (int f = 0; f < 3; f++) begin
            build(rnd_word(), rnd_word(), 16'($urandom), 16'($urandom), rnd_word(), rnd_word(), 1'b1, b);
            send_bytes(b, 2);
            wait_done();
            release_wait();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
